// File: rtl/csr_unit_m.sv
// csr_unit_m: machine-mode CSR file with trap/mret handling, 64-bit counters
// and synchronised timer/external interrupt lines.
module csr_unit_m #(
    parameter int          CNT_W       = 64,
    parameter int          HART_ID     = 0,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic [2:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_imm,
    input  logic        rs1_is_x0,
    input  logic [31:0] src1,
    output logic [31:0] csr_rdata,
    output logic        illegal_csr,
    input  logic        trap_req,
    input  logic        trap_irq,
    input  logic [3:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret,
    input  logic        instr_retire,
    input  logic        irq_timer_i,
    input  logic        irq_ext_i,
    output logic        irq_pending,
    output logic [3:0]  irq_cause,
    output logic [31:0] trap_target,
    output logic [31:0] mepc_out
);
    localparam logic [63:0] CNT_MASK = {64{1'b1}} >> (64 - CNT_W);

    logic        st_mie, st_mpie, ie_mt, ie_me;
    logic [31:0] mtvec, mscratch, mepc, mcause;
    logic [63:0] mcycle, minstret;
    logic [1:0]  tim_sync, ext_sync;
    logic [31:0] rval, src, wdata, base;
    logic        impl, ro, do_write, wr;

    always_comb begin
        rval = '0;
        impl = 1'b1;
        ro   = 1'b0;
        case (csr_addr)
            12'h300: rval = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
            12'h304: rval = {20'b0, ie_me, 3'b0, ie_mt, 7'b0};
            12'h305: rval = mtvec;
            12'h340: rval = mscratch;
            12'h341: rval = mepc;
            12'h342: rval = mcause;
            12'h344: begin rval = {20'b0, ext_sync[1], 3'b0, tim_sync[1], 7'b0}; ro = 1'b1; end
            12'hB00: rval = mcycle[31:0];
            12'hB80: rval = mcycle[63:32];
            12'hB02: rval = minstret[31:0];
            12'hB82: rval = minstret[63:32];
            12'hF14: begin rval = 32'(HART_ID); ro = 1'b1; end
            default: impl = 1'b0;
        endcase
    end

    // Set/clear forms with rs1 = x0 are pure reads, so they never fault on read-only CSRs.
    assign src         = csr_op[2] ? {27'b0, rs1_imm} : src1;
    assign do_write    = csr_we & (csr_op[1:0] == 2'b01 | (csr_op[1:0] != 2'b00 & ~rs1_is_x0));
    assign wdata       = csr_op[1:0] == 2'b01 ? src : csr_op[1:0] == 2'b10 ? (rval | src) : (rval & ~src);
    assign illegal_csr = csr_we & (~impl | (ro & do_write));
    assign csr_rdata   = illegal_csr ? '0 : rval;
    assign wr          = do_write & ~illegal_csr & ~trap_req & ~mret;

    assign base        = {mtvec[31:2], 2'b00};
    assign trap_target = (mtvec[0] & trap_irq) ? base + {26'b0, trap_cause, 2'b00} : base;
    assign irq_pending = st_mie & ((ie_mt & tim_sync[1]) | (ie_me & ext_sync[1]));
    assign irq_cause   = (ie_me & ext_sync[1]) ? 4'd11 : 4'd7;
    assign mepc_out    = mepc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie   <= 1'b0;
            st_mpie  <= 1'b0;
            ie_mt    <= 1'b0;
            ie_me    <= 1'b0;
            mtvec    <= RESET_MTVEC & ~32'h3;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mcycle   <= '0;
            minstret <= '0;
            tim_sync <= '0;
            ext_sync <= '0;
        end else begin
            tim_sync <= {tim_sync[0], irq_timer_i};
            ext_sync <= {ext_sync[0], irq_ext_i};
            if (trap_req) begin
                mepc    <= {trap_pc[31:2], 2'b00};
                mcause  <= {trap_irq, 27'b0, trap_cause};
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end else if (mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (wr) begin
                case (csr_addr)
                    12'h300: begin st_mie <= wdata[3]; st_mpie <= wdata[7]; end
                    12'h304: begin ie_mt <= wdata[7]; ie_me <= wdata[11]; end
                    12'h305: mtvec    <= {wdata[31:2], 1'b0, wdata[0]};
                    12'h340: mscratch <= wdata;
                    12'h341: mepc     <= {wdata[31:2], 2'b00};
                    12'h342: mcause   <= {wdata[31], 27'b0, wdata[3:0]};
                    default: ;
                endcase
            end
            // A half-write replaces that half and suppresses the increment for the cycle.
            mcycle   <= (wr & csr_addr == 12'hB00) ? {mcycle[63:32], wdata} & CNT_MASK :
                        (wr & csr_addr == 12'hB80) ? {wdata, mcycle[31:0]} & CNT_MASK :
                        (mcycle + 64'd1) & CNT_MASK;
            minstret <= (wr & csr_addr == 12'hB02) ? {minstret[63:32], wdata} & CNT_MASK :
                        (wr & csr_addr == 12'hB82) ? {wdata, minstret[31:0]} & CNT_MASK :
                        instr_retire ? (minstret + 64'd1) & CNT_MASK : minstret;
        end
    end
endmodule

// File: tb/tb_csr_unit_m.sv
// tb_csr_unit_m: table vectors, directed corner sequences and a randomised
// run against a mask-based CSR reference model.
module tb_csr_unit_m;
    localparam logic [31:0] RST_TVEC = 32'h8000_0003;
    localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RWI = 3'b101, RSI = 3'b110;

    logic        clk = 0, rst_n = 0;
    logic        csr_we, rs1_is_x0, trap_req, trap_irq, mret, instr_retire;
    logic        irq_timer_i = 0, irq_ext_i = 0;
    logic [2:0]  csr_op;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_imm;
    logic [31:0] src1, trap_pc, csr_rdata, trap_target, mepc_out;
    logic [3:0]  trap_cause, irq_cause;
    logic        illegal_csr, irq_pending;
    int tests = 0, errors = 0;

    csr_unit_m #(.CNT_W(64), .HART_ID(5), .RESET_MTVEC(RST_TVEC)) dut (
        .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr),
        .rs1_imm(rs1_imm), .rs1_is_x0(rs1_is_x0), .src1(src1), .csr_rdata(csr_rdata),
        .illegal_csr(illegal_csr), .trap_req(trap_req), .trap_irq(trap_irq),
        .trap_cause(trap_cause), .trap_pc(trap_pc), .mret(mret), .instr_retire(instr_retire),
        .irq_timer_i(irq_timer_i), .irq_ext_i(irq_ext_i), .irq_pending(irq_pending),
        .irq_cause(irq_cause), .trap_target(trap_target), .mepc_out(mepc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] src;
        logic [4:0]  imm;
        logic        x0;
        logic [31:0] rd;
        logic        ill;
    } vec_t;
    vec_t tbl[19];

    // Reference model: plain CSR words with per-address writable masks.
    logic [31:0] mr[int];
    logic [63:0] m_cyc, m_ins;
    logic [1:0]  m_t, m_e;

    function automatic logic [31:0] wmask(input int a);
        case (a)
            'h300: return 32'h0000_0088;
            'h304: return 32'h0000_0880;
            'h305: return 32'hFFFF_FFFD;
            'h340: return 32'hFFFF_FFFF;
            'h341: return 32'hFFFF_FFFC;
            'h342: return 32'h8000_000F;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mread(input int a);
        case (a)
            'h344: return (m_t[1] ? 32'h80 : 32'h0) | (m_e[1] ? 32'h800 : 32'h0);
            'hF14: return 32'd5;
            'hB00: return m_cyc[31:0];
            'hB80: return m_cyc[63:32];
            'hB02: return m_ins[31:0];
            'hB82: return m_ins[63:32];
            default: return mr.exists(a) ? mr[a] : 32'h0;
        endcase
    endfunction

    function automatic bit mimpl(input int a);
        return mr.exists(a) || a == 'h344 || a == 'hF14 || a == 'hB00 || a == 'hB80 || a == 'hB02 || a == 'hB82;
    endfunction

    task automatic model_reset();
        mr.delete();
        mr['h300] = 32'h1800; mr['h304] = 0; mr['h305] = RST_TVEC & ~32'h3;
        mr['h340] = 0; mr['h341] = 0; mr['h342] = 0;
        m_cyc = 0; m_ins = 0; m_t = 0; m_e = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        csr_we = 0; csr_op = 0; csr_addr = 0; src1 = 0; rs1_imm = 0; rs1_is_x0 = 0;
        trap_req = 0; trap_irq = 0; trap_cause = 0; trap_pc = 0; mret = 0; instr_retire = 0;
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] s,
                       input logic [4:0] imm, input logic x0);
        csr_we = 1; csr_op = op; csr_addr = a; src1 = s; rs1_imm = imm; rs1_is_x0 = x0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic peek(input logic [11:0] a, input string nm, input logic [31:0] exp);
        csr_we = 0; csr_addr = a; #1;
        chk(nm, csr_rdata, exp);
    endtask

    initial begin
        tbl[0]  = '{RS,  12'h305, 32'h0,         5'd0,  1'b1, 32'h8000_0000, 1'b0};
        tbl[1]  = '{RS,  12'h300, 32'h0,         5'd0,  1'b1, 32'h0000_1800, 1'b0};
        tbl[2]  = '{RS,  12'h300, 32'h88,        5'd0,  1'b0, 32'h0000_1800, 1'b0};
        tbl[3]  = '{RC,  12'h300, 32'hFFFF_FFFF, 5'd0,  1'b1, 32'h0000_1888, 1'b0};
        tbl[4]  = '{RS,  12'h300, 32'h0,         5'd0,  1'b1, 32'h0000_1888, 1'b0};
        tbl[5]  = '{RW,  12'hF14, 32'h1234,      5'd0,  1'b0, 32'h0,         1'b1};
        tbl[6]  = '{RS,  12'hF14, 32'h0,         5'd0,  1'b1, 32'h5,         1'b0};
        tbl[7]  = '{RW,  12'h123, 32'h1,         5'd0,  1'b0, 32'h0,         1'b1};
        tbl[8]  = '{RW,  12'h340, 32'hDEAD_BEEF, 5'd0,  1'b0, 32'h0,         1'b0};
        tbl[9]  = '{RS,  12'h340, 32'h0,         5'd0,  1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[10] = '{RWI, 12'h305, 32'h0,         5'h1F, 1'b0, 32'h8000_0000, 1'b0};
        tbl[11] = '{RS,  12'h305, 32'h0,         5'd0,  1'b1, 32'h0000_001D, 1'b0};
        tbl[12] = '{RC,  12'h340, 32'hFFFF_0000, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0};
        tbl[13] = '{RS,  12'h340, 32'h0,         5'd0,  1'b1, 32'h0000_BEEF, 1'b0};
        tbl[14] = '{RSI, 12'h344, 32'h0,         5'd1,  1'b0, 32'h0,         1'b1};
        tbl[15] = '{RW,  12'h341, 32'h1237,      5'd0,  1'b0, 32'h0,         1'b0};
        tbl[16] = '{RS,  12'h341, 32'h0,         5'd0,  1'b1, 32'h1234,      1'b0};
        tbl[17] = '{3'b000, 12'h340, 32'hFFFF_FFFF, 5'd0, 1'b0, 32'h0000_BEEF, 1'b0};
        tbl[18] = '{RS,  12'h340, 32'h0,         5'd0,  1'b1, 32'h0000_BEEF, 1'b0};

        idle();
        repeat (2) @(posedge clk);
        #1;
        peek(12'h305, "rst_mtvec", 32'h8000_0000);
        peek(12'h300, "rst_mstatus", 32'h1800);
        peek(12'hB00, "rst_mcycle", 32'h0);
        chk("rst_illegal", 32'(illegal_csr), 32'h0);
        chk("rst_pending", 32'(irq_pending), 32'h0);
        rst_n = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            peek(12'hB00, $sformatf("mcycle_%0d", i), 32'(i));
        end

        for (int i = 0; i < 19; i++) begin
            csr(tbl[i].op, tbl[i].addr, tbl[i].src, tbl[i].imm, tbl[i].x0);
            #1;
            chk($sformatf("tbl%0d_rdata", i), csr_rdata, tbl[i].rd);
            chk($sformatf("tbl%0d_illegal", i), 32'(illegal_csr), 32'(tbl[i].ill));
            tick();
        end
        idle();

        // Interrupt path: mstatus.MIE is already set by the table.
        csr(RW, 12'h304, 32'h80, 5'd0, 1'b0);
        tick(); idle();
        irq_timer_i = 1;
        tick();
        chk("irq_after_1", 32'(irq_pending), 32'h0);
        tick();
        chk("irq_after_2", 32'(irq_pending), 32'h1);
        chk("irq_cause", 32'(irq_cause), 32'd7);
        csr(RW, 12'h305, 32'h101, 5'd0, 1'b0);
        tick(); idle();
        trap_req = 1; trap_irq = 1; trap_cause = 7; trap_pc = 32'h1003;
        #1 chk("vec_target", trap_target, 32'h11C);
        tick(); idle();
        chk("trap_mepc", mepc_out, 32'h1000);
        peek(12'h300, "trap_mstatus", 32'h1880);
        peek(12'h342, "trap_mcause", 32'h8000_0007);
        chk("trap_pend_off", 32'(irq_pending), 32'h0);
        mret = 1;
        tick(); idle();
        peek(12'h300, "mret_mstatus", 32'h1888);
        chk("mret_pend_on", 32'(irq_pending), 32'h1);

        // trap_req beats mret and the CSR write in the same cycle.
        trap_req = 1; trap_pc = 32'h2000; trap_cause = 2; mret = 1;
        csr(RW, 12'h340, 32'h55, 5'd0, 1'b0);
        #1 chk("exc_target", trap_target, 32'h100);
        tick(); idle();
        peek(12'h340, "prio_mscratch", 32'h0000_BEEF);
        peek(12'h300, "prio_mstatus", 32'h1880);
        peek(12'h342, "prio_mcause", 32'h2);
        chk("prio_mepc", mepc_out, 32'h2000);

        // Counter half-writes and carry into the high half.
        csr(RW, 12'hB00, 32'hFFFF_FFFF, 5'd0, 1'b0);
        tick();
        csr(RW, 12'hB80, 32'h0, 5'd0, 1'b0);
        #1 chk("cyc_hi_old", csr_rdata, 32'h0);
        tick(); idle();
        peek(12'hB00, "cyc_lo_held", 32'hFFFF_FFFF);
        peek(12'hB80, "cyc_hi_written", 32'h0);
        tick();
        peek(12'hB00, "cyc_lo_wrap", 32'h0);
        peek(12'hB80, "cyc_hi_carry", 32'h1);

        // Asynchronous reset mid-cycle with the timer line still high.
        rst_n = 0;
        #1;
        peek(12'h300, "arst_mstatus", 32'h1800);
        peek(12'h340, "arst_mscratch", 32'h0);
        peek(12'hB80, "arst_cyc_hi", 32'h0);
        chk("arst_pending", 32'(irq_pending), 32'h0);
        irq_timer_i = 0;
        tick();
        rst_n = 1;
        model_reset();

        for (int n = 0; n < 500; n++) begin
            logic [11:0] alist[15];
            logic [31:0] old, s, w, base, st;
            logic wrt, ill;
            int a;
            alist = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'hB00,
                      12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h123, 12'hB01, 12'h7C0};
            csr_we = ($urandom % 4) != 0;
            csr_op = 3'($urandom);
            csr_addr = alist[$urandom % 15];
            rs1_is_x0 = ($urandom % 4) == 0;
            rs1_imm = rs1_is_x0 ? 5'd0 : 5'($urandom);
            src1 = $urandom;
            trap_req = ($urandom % 16) == 0;
            trap_irq = 1'($urandom);
            trap_cause = 4'($urandom);
            trap_pc = $urandom;
            mret = ($urandom % 16) == 0;
            instr_retire = 1'($urandom);
            if ($urandom % 8 == 0) irq_timer_i = ~irq_timer_i;
            if ($urandom % 8 == 0) irq_ext_i = ~irq_ext_i;
            #1;
            a = int'(csr_addr);
            old = mread(a);
            s = csr_op[2] ? {27'b0, rs1_imm} : src1;
            w = csr_op[1:0] == 2'b01 ? s : csr_op[1:0] == 2'b10 ? (old | s) : (old & ~s);
            wrt = csr_we && (csr_op[1:0] == 2'b01 || (csr_op[1:0] != 2'b00 && !rs1_is_x0));
            ill = csr_we && (!mimpl(a) || ((a == 'h344 || a == 'hF14) && wrt));
            base = mr['h305] & ~32'h3;
            st = mr['h300];
            chk("rnd_rdata", csr_rdata, ill ? 32'h0 : old);
            chk("rnd_illegal", 32'(illegal_csr), 32'(ill));
            chk("rnd_pending", 32'(irq_pending),
                32'(st[3] && ((mr['h304][7] && m_t[1]) || (mr['h304][11] && m_e[1]))));
            chk("rnd_cause", 32'(irq_cause), (mr['h304][11] && m_e[1]) ? 32'd11 : 32'd7);
            chk("rnd_target", trap_target,
                (mr['h305][0] && trap_irq) ? base + 32'(trap_cause) * 4 : base);
            chk("rnd_mepc", mepc_out, mr['h341]);
            // Advance the model to the state after the coming edge.
            if (!(wrt && !ill && !trap_req && !mret && (a == 'hB00 || a == 'hB80))) m_cyc = m_cyc + 1;
            if (!(wrt && !ill && !trap_req && !mret && (a == 'hB02 || a == 'hB82)) && instr_retire) m_ins = m_ins + 1;
            if (trap_req) begin
                mr['h341] = trap_pc & ~32'h3;
                mr['h342] = {trap_irq, 27'b0, trap_cause};
                mr['h300] = (st & ~32'h88) | (st[3] ? 32'h80 : 32'h0);
            end else if (mret) begin
                mr['h300] = (st & ~32'h88) | 32'h80 | (st[7] ? 32'h8 : 32'h0);
            end else if (wrt && !ill) begin
                if (mr.exists(a)) mr[a] = (mr[a] & ~wmask(a)) | (w & wmask(a));
                else if (a == 'hB00) m_cyc[31:0] = w;
                else if (a == 'hB80) m_cyc[63:32] = w;
                else if (a == 'hB02) m_ins[31:0] = w;
                else if (a == 'hB82) m_ins[63:32] = w;
            end
            m_t = {m_t[0], irq_timer_i};
            m_e = {m_e[0], irq_ext_i};
            tick();
        end
        idle();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
